// File: rtl/fetch_controller.sv
// Front-end fetch sequencer: owns the fetch PC, pulls two words per cycle from a
// dual-read instruction memory into a circular queue, and presents the two oldest entries to decode.
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] MEM_BASE = 32'h8000_0000,
  parameter logic [31:0] MEM_LAST = 32'h8000_FFFC,
  parameter int          FQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rd1_i,
  input  logic [31:0] imem_rd2_i,
  output logic        out_valid0_o,
  output logic [31:0] out_instr0_o,
  output logic [31:0] out_pc0_o,
  output logic        out_valid1_o,
  output logic [31:0] out_instr1_o,
  output logic [31:0] out_pc1_o,
  input  logic [1:0]  deq_cnt_i,
  output logic        fetch_fault_o
);
  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  state_t        state;
  logic [31:0]   pc_q;
  logic [PW-1:0] head, tail, head1, tail1;
  logic [CW-1:0] count;
  entry_t        fq [FQ_DEPTH];

  logic       fault_cond, space_ok, at_last, do_fetch;
  logic [1:0] enq_n, deq_n;

  assign head1 = head + PW'(1);
  assign tail1 = tail + PW'(1);

  assign fault_cond = (pc_q[1:0] != 2'b00) || (pc_q < MEM_BASE) || (pc_q > MEM_LAST);
  // Space is judged on the registered count; a same-cycle pop does not make room.
  assign space_ok   = (CW'(FQ_DEPTH) - count) >= CW'(2);
  assign at_last    = (pc_q == MEM_LAST);
  assign do_fetch   = (state == RUN) && fetch_en_i && !redirect_i && !fault_cond && space_ok;
  assign enq_n      = do_fetch ? (at_last ? 2'd1 : 2'd2) : 2'd0;

  always_comb begin
    deq_n = deq_cnt_i;
    if (CW'(deq_cnt_i) > count) deq_n = count[1:0];
    if (redirect_i)             deq_n = 2'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc_q  <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) fq[i] <= '0;
    end else if (redirect_i) begin
      state <= fetch_en_i ? RUN : IDLE;
      pc_q  <= redirect_pc_i;
      head  <= tail;
      count <= '0;
    end else begin
      head  <= head + PW'(deq_n);
      tail  <= tail + PW'(enq_n);
      count <= count + CW'(enq_n) - CW'(deq_n);
      if (do_fetch) begin
        fq[tail] <= '{instr: imem_rd1_i, pc: pc_q};
        if (!at_last) fq[tail1] <= '{instr: imem_rd2_i, pc: pc_q + 32'd4};
        pc_q <= pc_q + (at_last ? 32'd4 : 32'd8);
      end
      case (state)
        IDLE:    if (fetch_en_i) state <= RUN;
        RUN:     if (!fetch_en_i) state <= IDLE;
                 else if (fault_cond) state <= FAULT;
        default: state <= FAULT;
      endcase
    end
  end

  assign imem_addr_o   = pc_q;
  assign fetch_fault_o = (state == FAULT);
  assign out_valid0_o  = (count >= CW'(1));
  assign out_valid1_o  = (count >= CW'(2));
  assign out_instr0_o  = out_valid0_o ? fq[head].instr  : '0;
  assign out_pc0_o     = out_valid0_o ? fq[head].pc     : '0;
  assign out_instr1_o  = out_valid1_o ? fq[head1].instr : '0;
  assign out_pc1_o     = out_valid1_o ? fq[head1].pc    : '0;
endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: a queue-based reference model predicts the
// fetch queue contents; a negedge monitor compares the decode-facing outputs.
module tb_fetch_controller;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] MEM_BASE = 32'h8000_0000;
  localparam logic [31:0] MEM_LAST = 32'h8000_FFFC;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en, redirect;
  logic [31:0] redirect_pc, imem_addr, rd1, rd2;
  logic        v0, v1, fault;
  logic [31:0] instr0, pc0, instr1, pc1;
  logic [1:0]  deq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Memory image: word k from MEM_BASE holds (k+1)*0x11, so 0x11,0x22,0x33,...
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (((a - MEM_BASE) >> 2) + 32'd1) * 32'h11;
  endfunction

  assign rd1 = memf(imem_addr);
  assign rd2 = memf(imem_addr + 32'd4);

  fetch_controller #(.RESET_PC(RESET_PC), .MEM_BASE(MEM_BASE), .MEM_LAST(MEM_LAST), .FQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en_i(fetch_en), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .imem_addr_o(imem_addr), .imem_rd1_i(rd1), .imem_rd2_i(rd2),
    .out_valid0_o(v0), .out_instr0_o(instr0), .out_pc0_o(pc0),
    .out_valid1_o(v1), .out_instr1_o(instr1), .out_pc1_o(pc1),
    .deq_cnt_i(deq), .fetch_fault_o(fault)
  );

  // Reference model: mode 0=idle 1=run 2=fault, queue of predicted entries.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;
  ent_t        mq[$];
  int          mmode;
  logic [31:0] mpc;
  bit          m_flt, m_fetch;
  int          m_pops;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mmode = 0;
      mpc   = RESET_PC;
    end else if (redirect) begin
      mq.delete();
      mpc   = redirect_pc;
      mmode = fetch_en ? 1 : 0;
    end else begin
      m_flt   = (mpc % 4 != 0) || (mpc < MEM_BASE) || (mpc > MEM_LAST);
      m_fetch = (mmode == 1) && fetch_en && !m_flt && (DEPTH - mq.size() >= 2);
      m_pops  = (int'(deq) > mq.size()) ? mq.size() : int'(deq);
      repeat (m_pops) void'(mq.pop_front());
      if (m_fetch) begin
        mq.push_back('{memf(mpc), mpc});
        if (mpc == MEM_LAST) mpc = mpc + 4;
        else begin
          mq.push_back('{memf(mpc + 4), mpc + 4});
          mpc = mpc + 8;
        end
      end
      if (mmode == 0 && fetch_en) mmode = 1;
      else if (mmode == 1 && !fetch_en) mmode = 0;
      else if (mmode == 1 && m_flt) mmode = 2;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid0", 32'(v0), 32'(mq.size() >= 1));
      chk("valid1", 32'(v1), 32'(mq.size() >= 2));
      chk("instr0", instr0, mq.size() >= 1 ? mq[0].instr : 32'h0);
      chk("pc0",    pc0,    mq.size() >= 1 ? mq[0].pc    : 32'h0);
      chk("instr1", instr1, mq.size() >= 2 ? mq[1].instr : 32'h0);
      chk("pc1",    pc1,    mq.size() >= 2 ? mq[1].pc    : 32'h0);
      chk("fault",  32'(fault), 32'(mmode == 2));
      chk("imem_addr", imem_addr, mpc);
    end
  end

  function automatic logic [1:0] max_deq();
    return (mq.size() >= 2) ? 2'd2 : 2'(mq.size());
  endfunction

  task automatic step(input logic fe, input logic rd, input logic [31:0] rpc, input logic [1:0] dq);
    @(negedge clk);
    #1;
    fetch_en    = fe;
    redirect    = rd;
    redirect_pc = rpc;
    deq         = dq;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid0"}, 32'(v0), 32'h0);
    chk({tag, "_valid1"}, 32'(v1), 32'h0);
    chk({tag, "_instr0"}, instr0, 32'h0);
    chk({tag, "_pc1"},    pc1, 32'h0);
    chk({tag, "_fault"},  32'(fault), 32'h0);
    chk({tag, "_addr"},   imem_addr, RESET_PC);
  endtask

  logic [31:0] rpcs [6];

  initial begin
    rpcs = '{32'h8000_0100, 32'h8000_FFF0, 32'h8000_FFFC, 32'h8000_0002, 32'h7FFF_FFFC, 32'h8000_0000};
    rst_n = 1'b0; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = '0; deq = '0;
    #7;
    chk_reset_outputs("reset");
    @(negedge clk); #1 rst_n = 1'b1;

    // Fill from reset with no dequeue; queue saturates and PC parks.
    repeat (6) step(1, 0, 0, 0);
    @(negedge clk);
    chk("fill_addr",   imem_addr, 32'h8000_0010);
    chk("fill_instr0", instr0, 32'h11);
    chk("fill_pc1",    pc1, 32'h8000_0004);
    chk("fill_instr1", instr1, 32'h22);

    // Drain two per cycle for a stream across several pointer wraps.
    repeat (12) step(1, 0, 0, max_deq());

    // Refill, drop to IDLE while popping one, then redirect with 3 queued and deq=2.
    repeat (3) step(1, 0, 0, 0);
    step(0, 0, 0, max_deq() >= 1 ? 2'd1 : 2'd0);
    step(1, 1, 32'h8000_0100, max_deq());
    repeat (4) step(1, 0, 0, 0);
    @(negedge clk);
    chk("redir_pc0", pc0, 32'h8000_0100);

    // End of memory: one entry then fault until redirected back.
    step(1, 1, 32'h8000_FFFC, 0);
    repeat (5) step(1, 0, 0, 0);
    @(negedge clk);
    chk("eom_fault", 32'(fault), 32'h1);
    chk("eom_valid1", 32'(v1), 32'h0);
    step(1, 1, 32'h8000_0000, 0);
    repeat (3) step(1, 0, 0, max_deq());

    // Misaligned and below-base redirect targets.
    step(1, 1, 32'h8000_0002, 0);
    repeat (3) step(1, 0, 0, 0);
    step(1, 1, 32'h7FFF_FFFC, 0);
    repeat (3) step(1, 0, 0, 0);
    @(negedge clk);
    chk("low_fault", 32'(fault), 32'h1);
    chk("low_valid0", 32'(v0), 32'h0);
    step(1, 1, 32'h8000_0000, 0);

    // Randomized traffic with an asynchronous reset pulse in the middle.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midreset");
        @(negedge clk); #1 rst_n = 1'b1;
      end
      step(($urandom % 8) != 0, ($urandom % 20) == 0, rpcs[$urandom % 6],
           2'($urandom_range(0, int'(max_deq()))));
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
